// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters decoded into registered
// sync, display-enable, coordinate and frame/line marker outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          h_wrap, v_wrap;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic [CW-1:0] x_q, y_q;
  logic [15:0]   frame_out_q;

  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = h_wrap && (v_cnt_q == V_LAST);
    h_cnt_d     = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Decode of the current counter state; registered below so every output
  // describes the same (h, v) one clock later.
  always_comb begin
    de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    sof_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
    eol_d   = h_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      de_q        <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      frame_out_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      x_q         <= h_cnt_q;
      y_q         <= v_cnt_q;
      // Pre-increment value, so the count steps on the same output cycle as sof.
      frame_out_q <= frame_cnt_q;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign x         = x_q;
  assign y         = y_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign frame_cnt = frame_out_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a short-frame variant
// with full horizontal timing, and a tiny active-high-sync variant.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_med = 1'b1;

  always #5 clk = ~clk;

  // default 640x480 instance
  logic        d_hs, d_vs, d_de, d_sof, d_eol;
  logic [9:0]  d_x, d_y;
  logic [15:0] d_fc;
  // default horizontal, 15-line frame (8/2/2/3)
  logic        m_hs, m_vs, m_de, m_sof, m_eol;
  logic [9:0]  m_x, m_y;
  logic [15:0] m_fc;
  // tiny 8x6 instance, active-high syncs
  logic        s_hs, s_vs, s_de, s_sof, s_eol;
  logic [9:0]  s_x, s_y;
  logic [15:0] s_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .x(d_x), .y(d_y), .sof(d_sof), .eol(d_eol), .frame_cnt(d_fc)
  );

  vga_timing_gen #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_med (
    .clk(clk), .rst(rst_med), .hsync(m_hs), .vsync(m_vs), .de(m_de),
    .x(m_x), .y(m_y), .sof(m_sof), .eol(m_eol), .frame_cnt(m_fc)
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .SYNC_POL(1'b1)) u_sml (
    .clk(clk), .rst(rst), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .x(s_x), .y(s_y), .sof(s_sof), .eol(s_eol), .frame_cnt(s_fc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  int          eol_k[$];
  int          sof_k[$];
  int de_cnt[2], hs_cnt[2];
  int hs_bad, hs_first, xy_bad, eol_bad, vs_def, sof_def;
  int vs_cnt, vs_bad, de_late, de_total, found;

  initial begin
    hs_bad = 0; hs_first = -1; xy_bad = 0; eol_bad = 0; vs_def = 0; sof_def = 0;
    vs_cnt = 0; vs_bad = 0; de_late = 0; de_total = 0; found = 0;
    de_cnt = '{0, 0};
    hs_cnt = '{0, 0};

    // Expected tiny-instance stream: H_TOTAL=8, V_TOTAL=6, hsync x=5..6, vsync y=4.
    for (int k = 0; k < 144; k++) begin
      int h, v;
      logic [31:0] w;
      h = k % 8;
      v = (k / 8) % 6;
      w = '0;
      w[9:0]   = 10'(h);
      w[19:10] = 10'(v);
      w[20]    = (h == 7);
      w[21]    = (h == 0) && (v == 0);
      w[22]    = (h < 4) && (v < 3);
      w[23]    = (v == 4);
      w[24]    = (h == 5) || (h == 6);
      w[26:25] = 2'(k / 48);
      exp_q.push_back(w);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_de",    32'(d_de),  32'd0);
    check("rst_hs",    32'(d_hs),  32'd1);
    check("rst_vs",    32'(d_vs),  32'd1);
    check("rst_sof",   32'(d_sof), 32'd0);
    check("rst_eol",   32'(d_eol), 32'd0);
    check("rst_xy",    {12'd0, d_y, d_x}, 32'd0);
    check("rst_fc",    32'(d_fc),  32'd0);
    check("rst_s_hs",  32'(s_hs),  32'd0);
    check("rst_s_vs",  32'(s_vs),  32'd0);
    rst = 1'b0;

    for (int k = 0; k < 1600; k++) begin
      int line;
      @(negedge clk);
      line = k / 800;
      if (k == 0) begin
        check("rel_sof", 32'(d_sof), 32'd1);
        check("rel_de",  32'(d_de),  32'd1);
        check("rel_x",   32'(d_x),   32'd0);
        check("rel_y",   32'(d_y),   32'd0);
      end
      if (int'(d_x) != k % 800 || int'(d_y) != line) xy_bad++;
      if (d_de) de_cnt[line]++;
      if (!d_hs) begin
        hs_cnt[line]++;
        if (d_x < 10'd656 || d_x > 10'd751) hs_bad++;
        if (hs_first < 0) hs_first = int'(d_x);
      end
      if (d_eol) begin
        eol_k.push_back(k);
        if (d_x != 10'd799) eol_bad++;
      end
      if (!d_vs) vs_def++;
      if (d_sof) sof_def++;

      if (k < 144) begin
        logic [31:0] got;
        got = {5'd0, s_fc[1:0], s_hs, s_vs, s_de, s_sof, s_eol, s_y, s_x};
        check($sformatf("sml_vec_%0d", k), got, exp_q.pop_front());
      end
      if (k == 150) force u_sml.frame_cnt_q = 16'hFFFF;
      if (k == 151) begin
        check("sml_fc_preload", 32'(s_fc), 32'h0000FFFF);
        release u_sml.frame_cnt_q;
      end
      if (k == 192) begin
        check("sml_wrap_sof", 32'(s_sof), 32'd1);
        check("sml_fc_wrap",  32'(s_fc),  32'd0);
      end
    end

    check("def_xy_track",   32'(xy_bad),   32'd0);
    check("def_de_line0",   32'(de_cnt[0]), 32'd640);
    check("def_de_line1",   32'(de_cnt[1]), 32'd640);
    check("def_hs_line0",   32'(hs_cnt[0]), 32'd96);
    check("def_hs_line1",   32'(hs_cnt[1]), 32'd96);
    check("def_hs_start",   32'(hs_first), 32'd656);
    check("def_hs_range",   32'(hs_bad),   32'd0);
    check("def_eol_count",  32'(eol_k.size()), 32'd2);
    check("def_eol_x",      32'(eol_bad),  32'd0);
    if (eol_k.size() >= 2) check("def_eol_period", 32'(eol_k[1] - eol_k[0]), 32'd800);
    check("def_no_vsync",   32'(vs_def),   32'd0);
    check("def_sof_once",   32'(sof_def),  32'd1);

    rst_med = 1'b0;
    for (int k = 0; k <= 36000; k++) begin
      @(negedge clk);
      if (m_sof) sof_k.push_back(k);
      if (k < 36000) begin
        if (!m_vs) begin
          vs_cnt++;
          if (m_y != 10'd10 && m_y != 10'd11) vs_bad++;
        end
        if (m_de) begin
          de_total++;
          if (m_y >= 10'd8) de_late++;
        end
      end
      if (k == 11999) begin
        check("med_frame_eol", 32'(m_eol), 32'd1);
        check("med_frame_last_y", 32'(m_y), 32'd14);
        check("med_fc_before", 32'(m_fc), 32'd0);
      end
      if (k == 12000) check("med_fc_1", 32'(m_fc), 32'd1);
      if (k == 36000) begin
        check("med_fc_3",  32'(m_fc),  32'd3);
        check("med_sof_3", 32'(m_sof), 32'd1);
      end
    end
    check("med_sof_count", 32'(sof_k.size()), 32'd4);
    for (int i = 1; i < sof_k.size(); i++)
      check($sformatf("med_sof_period_%0d", i), 32'(sof_k[i] - sof_k[i-1]), 32'd12000);
    check("med_vs_cycles", 32'(vs_cnt),   32'd4800);
    check("med_vs_lines",  32'(vs_bad),   32'd0);
    check("med_de_late",   32'(de_late),  32'd0);
    check("med_de_total",  32'(de_total), 32'd15360);

    for (int i = 0; i < 5000 && found == 0; i++) begin
      @(negedge clk);
      if (m_x == 10'd300 && m_y == 10'd5) found = 1;
    end
    check("mid_found", 32'(found), 32'd1);
    rst_med = 1'b1;
    @(negedge clk);
    rst_med = 1'b0;
    check("mid_rst_xy",  {12'd0, m_y, m_x}, 32'd0);
    check("mid_rst_de",  32'(m_de),  32'd0);
    check("mid_rst_sof", 32'(m_sof), 32'd0);
    check("mid_rst_hv",  {30'd0, m_hs, m_vs}, 32'd3);
    check("mid_rst_fc",  32'(m_fc),  32'd0);
    @(negedge clk);
    check("mid_rel_sof", 32'(m_sof), 32'd1);
    check("mid_rel_de",  32'(m_de),  32'd1);
    check("mid_rel_xy",  {12'd0, m_y, m_x}, 32'd0);
    check("mid_rel_fc",  32'(m_fc),  32'd0);
    @(negedge clk);
    check("mid_next_x",  32'(m_x),   32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the video controller. Consumes the pixel clock produced by the pixel clock divider; top-level wiring connects that clock to this block's clk port.
- Generates horizontal and vertical sync, display-enable, pixel coordinates and frame/line markers for the downstream pixel source and the video output.
- Defaults are VGA 640x480@60 (800x525 total).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
CW, 10, width of coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock (driven by divider output)
rst  in  1  synchronous, active-high reset
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
de  out  1  display enable, high in the active region
x  out  CW  horizontal position (h counter value)
y  out  CW  vertical position (v counter value)
sof  out  1  one-cycle pulse at pixel (0,0)
eol  out  1  one-cycle pulse at the last pixel of every line (h = H_TOTAL-1)
frame_cnt  out  16  completed-frame counter

Behaviour:
Derived constants:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP

Counters:
- h_cnt in 0..H_TOTAL-1, incremented every clk.
- At H_TOTAL-1: h_cnt wraps to 0 and v_cnt advances.
- v_cnt in 0..V_TOTAL-1; wraps to 0 when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
- On that v wrap, frame_cnt increments, modulo 2^16 (0xFFFF -> 0x0000).

Decode (from counter state S):
- de = (h < H_ACTIVE) and (v < V_ACTIVE)
- hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (defaults 656..751)
- vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (defaults 490..491); full-line granularity, changes together with the h wrap
- sof = (h==0 and v==0)
- eol = (h==H_TOTAL-1)
- x = h, y = v

Output timing:
- All outputs are registered; latency is 1 clk from counter state to outputs.
- Outputs sampled after edge n show the decode of the counter state before edge n.
- Every output is mutually consistent for the same (h, v).

Reset:
- While rst is high at an edge: h_cnt = 0, v_cnt = 0, frame_cnt = 0.
- Outputs during reset: de = 0, sof = 0, eol = 0, x = 0, y = 0, hsync = vsync = inactive (= ~SYNC_POL).
- First edge with rst low: outputs take the decode of (0,0), i.e. sof = 1, de = 1, x = y = 0; counters advance to h = 1.
- Reset mid-frame: takes effect at the next edge regardless of counter state; no partial-line completion. frame_cnt is cleared, not incremented.

Boundary conditions:
- Line wrap and frame wrap occur in the same cycle at (H_TOTAL-1, V_TOTAL-1). eol is asserted for that pixel; sof follows on the next pixel.
- No combinational path from rst or counters to any output.

Test Plan:
- Reset release: hold rst 3 cycles, then release -> during reset de = 0, hsync = vsync = 1, sof = 0. Outputs after the first non-reset edge: sof = 1, de = 1, x = 0, y = 0.
- Line timing, defaults: count de-high cycles per line = 640. hsync low for exactly 96 cycles starting at x = 656. eol pulses at x = 799. Period between eol pulses = 800.
- Frame timing: vsync low for exactly 2 lines (y = 490, 491), i.e. 1600 cycles. sof period = 420000 cycles. de never high for y >= 480.
- frame_cnt: run 3 full frames -> frame_cnt = 3. Force or preload to 0xFFFF, cross a frame boundary -> 0x0000.
- Mid-frame reset: assert rst at x = 300, y = 200 for 1 cycle -> next outputs are the reset values; the output after that shows (0,0) with sof = 1; frame_cnt = 0.
- Small parameter set (H = 4/1/2/1, V = 3/1/1/1, SYNC_POL = 1): hsync high only at x = 5,6. vsync high only at y = 4. H_TOTAL = 8, V_TOTAL = 6 wraps verified cycle-exact.
